// File: rtl/mux_selftest_seq_if.sv
// Bus between the mux self-test sequencer and its controller/mux-under-test.
interface mux_selftest_seq_if;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 3;

  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fail_count;
  logic [VEC_W-1:0] first_fail_vec;

  modport master (
    output start, z,
    input  a, b, c, busy, done, pass, fail_count, first_fail_vec
  );

  modport slave (
    input  start, z,
    output a, b, c, busy, done, pass, fail_count, first_fail_vec
  );
endinterface

// File: rtl/mux_selftest_seq.sv
// Sequencer that walks all eight {a,b,c} vectors through a 2:1 mux and
// reports mismatches of z against c ? b : a.
module mux_selftest_seq #(
  parameter int unsigned SETTLE = 1
) (
  input logic               clk,
  input logic               reset,
  mux_selftest_seq_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 3;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             mismatch_c;

  // Case-inequality so an unknown z is treated as a failure in simulation.
  assign mismatch_c = (bus.z !== (bus.c ? bus.b : bus.a));

  // State register, with busy/done flopped from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT:    if (settle_cnt == '0) state_nxt = CHECK;
      CHECK:   state_nxt = (idx == VEC_W'(7)) ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered above.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      DRIVE, WAIT, CHECK: busy_nxt = 1'b1;
      FIN:                done_nxt = 1'b1;
      default:            ;
    endcase
  end

  // Vector drive, settle timing and result bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx                 <= '0;
      settle_cnt          <= '0;
      bus.a               <= 1'b0;
      bus.b               <= 1'b0;
      bus.c               <= 1'b0;
      bus.pass            <= 1'b0;
      bus.fail_count      <= '0;
      bus.first_fail_vec  <= '0;
    end else begin
      case (state)
        IDLE: begin
          {bus.a, bus.b, bus.c} <= '0;
          if (bus.start) begin
            idx                <= '0;
            bus.pass           <= 1'b0;
            bus.fail_count     <= '0;
            bus.first_fail_vec <= '0;
          end
        end
        DRIVE: begin
          {bus.a, bus.b, bus.c} <= idx;
          settle_cnt            <= CNT_W'(SETTLE - 1);
        end
        WAIT: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
        end
        CHECK: begin
          if (mismatch_c) begin
            bus.fail_count <= bus.fail_count + CNT_W'(1);
            if (bus.fail_count == '0) bus.first_fail_vec <= idx;
          end
          if (idx != VEC_W'(7)) idx <= idx + VEC_W'(1);
        end
        FIN: begin
          bus.pass <= (bus.fail_count == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_selftest_seq.sv
// Directed bench for mux_selftest_seq: good, stuck and swapped muxes, reset
// abort, back-to-back runs and a SETTLE=3 instance with ignored starts.
module tb_mux_selftest_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mode = 0;  // 0 good, 1 stuck-0, 2 stuck-1, 3 swapped inputs

  always #5 clk = ~clk;

  mux_selftest_seq_if bus1 ();
  mux_selftest_seq_if bus3 ();

  mux_selftest_seq #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mux_selftest_seq #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  function automatic logic zf(int m, logic a, logic b, logic c);
    case (m)
      0:       return c ? b : a;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return c ? a : b;
    endcase
  endfunction

  assign bus1.z = zf(mode, bus1.a, bus1.b, bus1.c);
  assign bus3.z = zf(0, bus3.a, bus3.b, bus3.c);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with dut1 idle. Cycle 1 is the one begun by the
  // accept edge; done must first be seen in cycle 8*(2+1)+1 = 25.
  task automatic run1(string tag, int fc, int ffv, int ps);
    int n;
    n = 1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk({tag, "_busy_c1"}, 32'(bus1.busy), 1);
    while (!bus1.done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) chk({tag, "_vec1"}, 32'({bus1.a, bus1.b, bus1.c}), 1);
    end
    chk({tag, "_done_cycle"}, n, 25);
    chk({tag, "_busy_fin"}, 32'(bus1.busy), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus1.done), 0);
    chk({tag, "_fail_count"}, 32'(bus1.fail_count), fc);
    chk({tag, "_first_fail"}, 32'(bus1.first_fail_vec), ffv);
    chk({tag, "_pass"}, 32'(bus1.pass), ps);
  endtask

  initial begin
    int n;
    int dn;
    int dc;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_abc", 32'({bus1.a, bus1.b, bus1.c}), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_done", 32'(bus1.done), 0);
    chk("rst_pass", 32'(bus1.pass), 0);
    chk("rst_fc", 32'(bus1.fail_count), 0);
    chk("rst_ffv", 32'(bus1.first_fail_vec), 0);

    // Start on the first edge after release.
    reset = 1'b0;
    run1("good", 0, 0, 1);
    mode = 1; run1("stuck0", 4, 3, 0);
    mode = 2; run1("stuck1", 4, 0, 0);
    mode = 3; run1("swap", 4, 2, 0);

    // Abort during vector 5 (visible in cycle 3*5+2 = 17).
    mode = 1;
    dn = 0;
    n = 1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    while (n < 17) begin
      @(negedge clk);
      n++;
      if (bus1.done) dn++;
    end
    chk("abort_vec5", 32'({bus1.a, bus1.b, bus1.c}), 5);
    chk("abort_fc_pre", 32'(bus1.fail_count), 2);
    reset = 1'b1;
    #1;
    chk("abort_abc", 32'({bus1.a, bus1.b, bus1.c}), 0);
    chk("abort_busy", 32'(bus1.busy), 0);
    chk("abort_fc", 32'(bus1.fail_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus1.done) dn++;
    end
    chk("abort_no_done", dn, 0);
    mode = 0;
    run1("after_rst", 0, 0, 1);

    // Start held high: FIN, one IDLE cycle, then the next run.
    bus1.start = 1'b1;
    n = 0;
    while (!bus1.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done1", n, 25);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus1.busy), 0);
    @(negedge clk);
    chk("b2b_rerun_busy", 32'(bus1.busy), 1);
    bus1.start = 1'b0;
    n = 1;
    while (!bus1.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done2", n, 25);
    @(negedge clk);
    chk("b2b_pass", 32'(bus1.pass), 1);

    // SETTLE=3: 5 cycles per vector, done in cycle 41, extra starts ignored.
    dn = 0;
    dc = 0;
    n = 1;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      bus3.start = (n >= 5 && n <= 8);
      if (bus3.done) begin
        dn++;
        if (dn == 1) dc = n;
      end
      if (n == 17) chk("s3_vec3_first", 32'({bus3.a, bus3.b, bus3.c}), 3);
      if (n == 21) chk("s3_vec3_last", 32'({bus3.a, bus3.b, bus3.c}), 3);
      if (n == 22) chk("s3_vec4", 32'({bus3.a, bus3.b, bus3.c}), 4);
    end
    chk("s3_done_count", dn, 1);
    chk("s3_done_cycle", dc, 41);
    chk("s3_busy_end", 32'(bus3.busy), 0);
    chk("s3_pass", 32'(bus3.pass), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_selftest_seq.md
MUX_SELFTEST_SEQ -- requirements
Module: mux_selftest_seq

Interface
REQ-001 The module SHALL have parameter SETTLE, default 1, range 1..15, giving the number of cycles between applying a vector and sampling z.
REQ-002 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request one full 8-vector self-test; sampled only in IDLE.
REQ-005 a  output  1  data input 0 to the mux under test.
REQ-006 b  output  1  data input 1 to the mux under test.
REQ-007 c  output  1  select to the mux under test.
REQ-008 z  input  1  mux-under-test output; the expected function is z = c ? b : a.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  single-cycle pulse at end of run.
REQ-011 pass  output  1  high when the last completed run had zero mismatches.
REQ-012 fail_count  output  4  number of mismatching vectors in the current or last run, 0..8.
REQ-013 first_fail_vec  output  3  {a,b,c} of the first mismatching vector; valid only when fail_count != 0.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK and FIN.
REQ-015 Vector index idx SHALL be 3 bits, mapped {a,b,c} = idx, and applied in order 0,1,...,7.
REQ-016 a, b and c SHALL be driven from registers, never combinationally from idx.
REQ-017 IDLE with start=1: clear fail_count, pass and first_fail_vec; set idx=0; go to DRIVE.
REQ-018 IDLE with start=0: remain in IDLE; a, b, c = 0.
REQ-019 DRIVE: register a, b, c from idx; load the settle counter with SETTLE-1; go to WAIT.
REQ-020 WAIT: decrement the settle counter each cycle; at 0 go to CHECK; WAIT SHALL last exactly SETTLE cycles.
REQ-021 CHECK: compare z against (c ? b : a) using the currently driven a, b, c.
REQ-022 CHECK mismatch: increment fail_count; if fail_count was 0, capture idx into first_fail_vec.
REQ-023 CHECK with idx=7: go to FIN; otherwise increment idx and go to DRIVE.
REQ-024 FIN: done=1 for exactly one cycle; pass = (fail_count==0); go to IDLE.
REQ-025 Cycles per vector SHALL be 2+SETTLE, so done asserts 8*(2+SETTLE)+1 cycles after the start-accept edge.
REQ-026 busy SHALL be high in DRIVE, WAIT and CHECK, and low in IDLE and FIN.
REQ-027 start while busy or in FIN SHALL be ignored and SHALL NOT be queued.
REQ-028 start held high continuously SHALL begin a new run on the cycle after FIN (back-to-back runs).
REQ-029 pass, fail_count and first_fail_vec SHALL hold their final values after a run until the next accepted start.
REQ-030 fail_count SHALL NOT wrap; its maximum is 8, and 4 bits suffice.
REQ-031 An X or Z on z at CHECK SHALL count as a mismatch (compare with case-inequality semantics in simulation).

Reset
REQ-032 reset=1 SHALL immediately force: state=IDLE, idx=0, a=b=c=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0.
REQ-033 Reset mid-run SHALL abandon the run with no done pulse; the next start SHALL begin at idx=0.
REQ-034 Release of reset SHALL require no extra cycles; start may be accepted on the first clock edge after reset deasserts.

Verification
REQ-035 Good mux (z=c?b:a), SETTLE=1, one start pulse -> done at 25 cycles after accept, pass=1, fail_count=0, busy low after done.
REQ-036 z stuck at 0 -> fail_count=4 (vectors 3,4,6,7), first_fail_vec=3'b011, pass=0.
REQ-037 z stuck at 1 -> fail_count=4 (vectors 0,1,2,5), first_fail_vec=3'b000, pass=0.
REQ-038 Swapped-input mux (z=c?a:b) -> fail_count=4 (vectors 2,3,4,5), first_fail_vec=3'b010, pass=0.
REQ-039 Reset asserted during vector 5, then start after release -> no done pulse during the aborted run; new run begins at {a,b,c}=000; results match REQ-035.
REQ-040 SETTLE=3 with extra start pulses while busy -> exactly one done pulse, at 41 cycles after accept; a, b, c held stable for 5 cycles per vector.
